// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: default width, op codes and the
// fixed-priority decode of the control unit's select lines.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd3;
  localparam logic [2:0] OP_NONE = 3'd4;

  // Add > Sub > Mul > Pass when more than one select is asserted.
  function automatic logic [2:0] prio_encode(input logic add, input logic sub,
                                             input logic mul, input logic pass);
    logic [2:0] op;
    if (add)       op = OP_ADD;
    else if (sub)  op = OP_SUB;
    else if (mul)  op = OP_MUL;
    else if (pass) op = OP_PASS;
    else           op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/alu_mul.sv
// Combinational unsigned W x W -> 2W shift-add array multiplier.
module alu_mul
  import alu_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH
) (
  input  logic [Width-1:0]   a,
  input  logic [Width-1:0]   b,
  output logic [2*Width-1:0] prod
);

  logic [2*Width-1:0] a_ext;

  assign a_ext = {{Width{1'b0}}, a};

  // One partial-product row per multiplier bit, accumulated in order.
  always_comb begin
    prod = '0;
    for (int i = 0; i < int'(Width); i++) begin
      if (b[i]) prod = prod + (a_ext << i);
    end
  end

endmodule

// File: rtl/alu.sv
// Datapath ALU: priority-decoded add/sub/mul/pass with a single registered
// result stage carrying zero and carry/borrow/overflow flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Alu_Add,
  input  logic                  Alu_Sub,
  input  logic                  Alu_Mul,
  input  logic                  Alu_Pass,
  input  logic [DATA_WIDTH-1:0] Reg1_Out,
  input  logic [DATA_WIDTH-1:0] Reg2_Out,
  output logic [DATA_WIDTH-1:0] Alu_Out,
  output logic                  Alu_Zero,
  output logic                  Alu_Carry
);

  logic [2:0]              op;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH:0]     diff;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   out_d;
  logic                    zero_d;
  logic                    carry_d;

  assign op   = prio_encode(Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass);
  assign sum  = {1'b0, Reg1_Out} + {1'b0, Reg2_Out};
  // Bit W of the widened difference is the borrow.
  assign diff = {1'b0, Reg1_Out} - {1'b0, Reg2_Out};

  alu_mul #(
    .Width(DATA_WIDTH)
  ) u_mul (
    .a   (Reg1_Out),
    .b   (Reg2_Out),
    .prod(prod)
  );

  always_comb begin
    out_d   = Alu_Out;
    carry_d = Alu_Carry;
    zero_d  = Alu_Zero;
    case (op)
      OP_ADD: begin
        out_d   = sum[DATA_WIDTH-1:0];
        carry_d = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        out_d   = diff[DATA_WIDTH-1:0];
        carry_d = diff[DATA_WIDTH];
      end
      OP_MUL: begin
        out_d   = prod[DATA_WIDTH-1:0];
        carry_d = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      OP_PASS: begin
        out_d   = Reg2_Out;
        carry_d = 1'b0;
      end
      default: ;
    endcase
    if (op != OP_NONE) zero_d = (out_d == '0);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Alu_Out   <= '0;
      Alu_Zero  <= 1'b1;
      Alu_Carry <= 1'b0;
    end else begin
      Alu_Out   <= out_d;
      Alu_Zero  <= zero_d;
      Alu_Carry <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized one-hot ops
// against an arithmetic reference model.
module tb_alu;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass;
  logic [15:0] Reg1_Out, Reg2_Out;
  logic [15:0] Alu_Out;
  logic        Alu_Zero, Alu_Carry;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_out;
  logic        exp_z, exp_c;

  alu #(
    .DATA_WIDTH(16)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Alu_Add  (Alu_Add),
    .Alu_Sub  (Alu_Sub),
    .Alu_Mul  (Alu_Mul),
    .Alu_Pass (Alu_Pass),
    .Reg1_Out (Reg1_Out),
    .Reg2_Out (Reg2_Out),
    .Alu_Out  (Alu_Out),
    .Alu_Zero (Alu_Zero),
    .Alu_Carry(Alu_Carry)
  );

  always #5 Clk = ~Clk;

  // Reference: plain integer arithmetic on the unsigned operands.
  task automatic model(input logic ad, input logic sb, input logic ml, input logic ps,
                       input logic [15:0] a, input logic [15:0] b);
    longint unsigned x, y, r;
    x = longint'(a);
    y = longint'(b);
    if (ad) begin
      r = x + y;
      exp_c = (r >= 65536);
    end else if (sb) begin
      r = (x + 65536 - y) % 65536;
      exp_c = (x < y);
    end else if (ml) begin
      r = x * y;
      exp_c = (r >= 65536);
    end else if (ps) begin
      r = y;
      exp_c = 1'b0;
    end else begin
      return;
    end
    exp_out = 16'(r % 65536);
    exp_z   = (exp_out == 16'h0000);
  endtask

  // Apply one set of inputs at the falling edge; return just after the next rising edge.
  task automatic do_op(input logic ad, input logic sb, input logic ml, input logic ps,
                       input logic [15:0] a, input logic [15:0] b);
    @(negedge Clk);
    Alu_Add  = ad;
    Alu_Sub  = sb;
    Alu_Mul  = ml;
    Alu_Pass = ps;
    Reg1_Out = a;
    Reg2_Out = b;
    model(ad, sb, ml, ps, a, b);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_init: got out=%h z=%b c=%b want 0000 1 0", Alu_Out, Alu_Zero,
               Alu_Carry);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234);
    n_tests++;
    if (Alu_Out !== 16'h1234) begin
      n_fail++;
      $display("FAIL reset_load: got %h want 1234", Alu_Out);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got out=%h z=%b c=%b want 0000 1 0", Alu_Out, Alu_Zero,
               Alu_Carry);
    end
    exp_out = 16'h0000;
    exp_z   = 1'b1;
    exp_c   = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_add;
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0007);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'h000C, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_5_7: got %h z=%b c=%b want 000c 0 0", Alu_Out, Alu_Zero, Alu_Carry);
    end
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL add_wrap: got %h z=%b c=%b want 0000 1 1", Alu_Out, Alu_Zero, Alu_Carry);
    end
  endtask

  task automatic test_sub;
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 16'd10, 16'd3);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'd7, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_10_3: got %h z=%b c=%b want 0007 0 0", Alu_Out, Alu_Zero, Alu_Carry);
    end
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd10);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'hFFF9, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_borrow: got %h z=%b c=%b want fff9 0 1", Alu_Out, Alu_Zero, Alu_Carry);
    end
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 16'd9, 16'd9);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_zero: got %h z=%b c=%b want 0000 1 0", Alu_Out, Alu_Zero, Alu_Carry);
    end
  endtask

  task automatic test_mul;
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 16'd12, 16'd11);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'd132, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_12_11: got %h z=%b c=%b want 0084 0 0", Alu_Out, Alu_Zero, Alu_Carry);
    end
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0100);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_ovf: got %h z=%b c=%b want 0000 1 1", Alu_Out, Alu_Zero, Alu_Carry);
    end
  endtask

  task automatic test_pass_hold;
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'hABCD);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'hABCD, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL pass: got %h z=%b c=%b want abcd 0 0", Alu_Out, Alu_Zero, Alu_Carry);
    end
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h7777);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'hABCD, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_hold: got %h z=%b c=%b want abcd 0 0", Alu_Out, Alu_Zero, Alu_Carry);
    end
  endtask

  task automatic test_priority;
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 16'd5);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'd9, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_add_mul: got %h z=%b c=%b want 0009 0 0", Alu_Out, Alu_Zero,
               Alu_Carry);
    end
    do_op(1'b0, 1'b1, 1'b1, 1'b1, 16'd4, 16'd5);
    n_tests++;
    if ({Alu_Out, Alu_Zero, Alu_Carry} !== {16'hFFFF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_sub_mul_pass: got %h z=%b c=%b want ffff 0 1", Alu_Out, Alu_Zero,
               Alu_Carry);
    end
  endtask

  task automatic test_random;
    logic [3:0]  sel;
    logic [15:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      sel = 4'b0001 << $urandom_range(3);
      a = 16'($urandom());
      b = 16'($urandom());
      // Small operands now and then to exercise zero results and equal-operand subtracts.
      if ($urandom_range(7) == 0) begin
        a = 16'($urandom_range(3));
        b = 16'($urandom_range(3));
      end
      do_op(sel[0], sel[1], sel[2], sel[3], a, b);
      n_tests++;
      if ({Alu_Out, Alu_Zero, Alu_Carry} !== {exp_out, exp_z, exp_c}) begin
        n_fail++;
        $display("FAIL random[%0d] sel=%b a=%h b=%h: got %h z=%b c=%b want %h z=%b c=%b", i, sel,
                 a, b, Alu_Out, Alu_Zero, Alu_Carry, exp_out, exp_z, exp_c);
      end
    end
  endtask

  initial begin
    Rst_n    = 1'b0;
    Alu_Add  = 1'b0;
    Alu_Sub  = 1'b0;
    Alu_Mul  = 1'b0;
    Alu_Pass = 1'b0;
    Reg1_Out = '0;
    Reg2_Out = '0;
    exp_out  = '0;
    exp_z    = 1'b1;
    exp_c    = 1'b0;
    #12;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_pass_hold();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
